// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump controller: FSM state
// encodings and the byte width used to serialise register words.
package regfile_dump_pkg;

    // Width of one transmitted byte; words are sliced into chunks of this size.
    localparam int BYTE_W = 8;

    // Dump sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        ADDR  = 3'd2,
        LATCH = 3'd3,
        SEND  = 3'd4,
        WAIT  = 3'd5,
        NEXT  = 3'd6,
        DONE  = 3'd7
    } dump_state_t;

endpackage : regfile_dump_pkg

// File: rtl/regfile_dump_ctrl.sv
// Register-file dump controller. On request it stalls the pipeline, waits for
// it to drain, then walks every register through read port 1 and streams each
// word MSB-first to a UART one byte at a time, pulsing dump_done at the end.
module regfile_dump_ctrl
    import regfile_dump_pkg::*;
#(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         dump_req,
    input  logic         pipe_idle,
    input  logic [W-1:0] pipe_rd_addr,
    output logic [W-1:0] rf_rd_addr,
    input  logic [B-1:0] rf_rd_data,
    output logic         stall,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    input  logic         tx_done,
    output logic         busy,
    output logic         dump_done
);

    localparam int NBYTES = B / BYTE_W;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [W-1:0]     LAST_REG  = '1;

    dump_state_t      state, state_nxt;
    logic [W-1:0]     reg_idx, reg_idx_nxt;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
    logic [B-1:0]     shift_q, shift_nxt;

    // Next-state and datapath-update decode for the dump sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_nxt    = state;
        reg_idx_nxt  = reg_idx;
        byte_cnt_nxt = byte_cnt;
        shift_nxt    = shift_q;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    state_nxt   = DRAIN;
                    reg_idx_nxt = '0;
                end
            end
            DRAIN: begin
                reg_idx_nxt = '0;
                if (pipe_idle) state_nxt = ADDR;
            end
            ADDR: begin
                state_nxt = LATCH;
            end
            LATCH: begin
                shift_nxt    = rf_rd_data;
                byte_cnt_nxt = '0;
                state_nxt    = SEND;
            end
            SEND: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    shift_nxt = shift_q << BYTE_W;
                    if (byte_cnt == LAST_BYTE) begin
                        state_nxt = NEXT;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 1'b1;
                        state_nxt    = SEND;
                    end
                end
            end
            NEXT: begin
                if (reg_idx == LAST_REG) begin
                    state_nxt = DONE;
                end else begin
                    reg_idx_nxt = reg_idx + 1'b1;
                    state_nxt   = ADDR;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset aborts any dump in progress immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    // Datapath registers and registered outputs, all derived from the next
    // state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_idx   <= '0;
            byte_cnt  <= '0;
            shift_q   <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            stall     <= 1'b0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            reg_idx   <= reg_idx_nxt;
            byte_cnt  <= byte_cnt_nxt;
            shift_q   <= shift_nxt;
            tx_start  <= (state_nxt == SEND);
            stall     <= (state_nxt != IDLE);
            busy      <= (state_nxt != IDLE);
            dump_done <= (state_nxt == DONE);
            // The byte presented in SEND is the top of the word as it will be
            // after this edge's capture or shift.
            if (state_nxt == SEND) begin
                tx_data <= shift_nxt[B-1 -: BYTE_W];
            end
        end
    end

    // Read-port address: the pipeline owns the port until it has drained.
    always_comb begin
        rf_rd_addr = reg_idx;
        if (state == IDLE || state == DRAIN) begin
            rf_rd_addr = pipe_rd_addr;
        end
    end

endmodule : regfile_dump_ctrl

// File: tb/tb_regfile_dump_ctrl.sv
// Directed testbench for regfile_dump_ctrl with a behavioural register file
// and a UART model that answers each tx_start with tx_done 10 cycles later.
module tb_regfile_dump_ctrl;

    localparam int B = 32;
    localparam int W = 5;
    localparam int NREG = 2 ** W;
    localparam int NBYTE_TOTAL = NREG * B / 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         dump_req;
    logic         pipe_idle;
    logic [W-1:0] pipe_rd_addr;
    logic [W-1:0] rf_rd_addr;
    logic [B-1:0] rf_rd_data;
    logic         stall;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_done;
    logic         busy;
    logic         dump_done;

    logic         uart_done = 1'b0;
    logic         spur_done = 1'b0;

    logic [B-1:0] regs [NREG];
    logic [7:0]   bytes [$];
    int           done_cnt  = 0;
    int           stall_err = 0;
    int           n_tests   = 0;
    int           n_fail    = 0;

    regfile_dump_ctrl #(.B(B), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .dump_req     (dump_req),
        .pipe_idle    (pipe_idle),
        .pipe_rd_addr (pipe_rd_addr),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .stall        (stall),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done      (tx_done),
        .busy         (busy),
        .dump_done    (dump_done)
    );

    always #5 clk = ~clk;

    assign rf_rd_data = regs[rf_rd_addr];
    assign tx_done    = uart_done | spur_done;

    // UART model: tx_done is high for one cycle, 10 cycles after tx_start.
    initial begin
        int cd;
        cd = 0;
        forever begin
            @(negedge clk);
            uart_done = 1'b0;
            if (reset) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) uart_done = 1'b1;
                end
                if (tx_start) cd = 10;
            end
        end
    end

    // Byte/event monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) bytes.push_back(tx_data);
            if (dump_done) done_cnt++;
            if (busy !== stall) stall_err++;
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_req();
        @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        #1;
    endtask

    // Wait for dump_done within a cycle budget; optionally inject a spurious
    // tx_done during SEND of byte 2 and a second dump_req during register 5.
    task automatic wait_done(input string tag, input int budget, input bit inject, input int base);
        int start_done;
        bit got, spur_sent, req_sent;
        start_done = done_cnt;
        got = 1'b0;
        spur_sent = 1'b0;
        req_sent = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            #1;
            spur_done = 1'b0;
            dump_req  = 1'b0;
            if (inject) begin
                if (!spur_sent && tx_start && bytes.size() == base + 3) begin
                    spur_done = 1'b1;
                    spur_sent = 1'b1;
                end
                if (!req_sent && bytes.size() == base + 21) begin
                    dump_req = 1'b1;
                    req_sent = 1'b1;
                end
            end
            if (done_cnt != start_done) got = 1'b1;
        end
        spur_done = 1'b0;
        dump_req  = 1'b0;
        check({tag, "_done_seen"}, 64'(got), 64'd1);
    endtask

    task automatic check_stream(input string tag, input int base);
        logic [31:0] w;
        check({tag, "_byte_count"}, 64'(bytes.size() - base), 64'(NBYTE_TOTAL));
        for (int i = 0; i < NBYTE_TOTAL && base + i < bytes.size(); i++) begin
            w = 32'hA0B0C000 + 32'(i / 4);
            check($sformatf("%s_byte%0d", tag, i), 64'(bytes[base + i]), 64'(w[31 - 8 * (i % 4) -: 8]));
        end
    endtask

    initial begin
        int base, dbase;
        bit tx_seen, hit;

        for (int k = 0; k < NREG; k++) regs[k] = 32'hA0B0C000 + 32'(k);
        reset        = 1'b1;
        dump_req     = 1'b0;
        pipe_idle    = 1'b1;
        pipe_rd_addr = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall",     64'(stall),     64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_tx_start",  64'(tx_start),  64'd0);
        check("rst_dump_done", 64'(dump_done), 64'd0);
        check("rst_tx_data",   64'(tx_data),   64'h00);
        @(negedge clk);
        reset = 1'b0;

        // IDLE: read-address mux follows the pipeline combinationally.
        for (int a = 0; a < NREG; a++) begin
            @(negedge clk);
            pipe_rd_addr = W'(a);
            #1;
            check($sformatf("idle_addr%0d", a), 64'(rf_rd_addr), 64'(a));
        end

        // Spurious tx_done in IDLE.
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        #1;
        check("spur_idle_busy",     64'(busy),     64'd0);
        check("spur_idle_tx_start", 64'(tx_start), 64'd0);
        check("spur_idle_count",    64'(bytes.size()), 64'd0);

        // Dump 1: pipeline already idle, spurious tx_done in SEND, extra
        // dump_req during register 5.
        base  = bytes.size();
        dbase = done_cnt;
        pulse_req();
        check("d1_stall_next", 64'(stall), 64'd1);
        check("d1_busy_next",  64'(busy),  64'd1);
        wait_done("d1", 3000, 1'b1, base);
        repeat (40) @(negedge clk);
        #1;
        check("d1_done_pulses", 64'(done_cnt - dbase), 64'd1);
        check("d1_idle_after",  64'(busy),  64'd0);
        check("d1_stall_after", 64'(stall), 64'd0);
        check_stream("d1", base);

        // Dump 2: pipeline busy for 20 cycles after the request.
        pipe_idle = 1'b0;
        base  = bytes.size();
        dbase = done_cnt;
        pulse_req();
        check("d2_stall_next", 64'(stall), 64'd1);
        tx_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pipe_rd_addr = W'(i * 7 + 3);
            #1;
            check($sformatf("d2_drain_addr%0d", i), 64'(rf_rd_addr), 64'((i * 7 + 3) % NREG));
            if (tx_start || !stall) tx_seen = 1'b1;
            @(negedge clk);
            #1;
        end
        check("d2_drain_quiet", 64'(tx_seen), 64'd0);
        pipe_idle    = 1'b1;
        pipe_rd_addr = W'(9);
        @(negedge clk);
        #1;
        check("d2_addr_reg0", 64'(rf_rd_addr), 64'd0);
        wait_done("d2", 3000, 1'b0, base);
        repeat (5) @(negedge clk);
        check("d2_done_pulses", 64'(done_cnt - dbase), 64'd1);
        check_stream("d2", base);

        // Dump 3: reset during register 17, byte 2.
        base = bytes.size();
        pulse_req();
        hit = 1'b0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clk);
            #1;
            if (bytes.size() >= base + 17 * 4 + 3) hit = 1'b1;
        end
        check("d3_reached_r17b2", 64'(hit), 64'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("d3_rst_stall",    64'(stall),    64'd0);
        check("d3_rst_busy",     64'(busy),     64'd0);
        check("d3_rst_tx_start", 64'(tx_start), 64'd0);
        check("d3_rst_tx_data",  64'(tx_data),  64'h00);
        pipe_rd_addr = W'(22);
        #1;
        check("d3_rst_addr_mux", 64'(rf_rd_addr), 64'd22);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("d3_no_bytes_after_rst", 64'(bytes.size() - base), 64'(17 * 4 + 3));

        // Dump 4: restart after reset begins again at register 0.
        base  = bytes.size();
        dbase = done_cnt;
        pulse_req();
        wait_done("d4", 3000, 1'b0, base);
        repeat (5) @(negedge clk);
        check("d4_done_pulses", 64'(done_cnt - dbase), 64'd1);
        check_stream("d4", base);

        check("stall_tracks_busy", 64'(stall_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_dump_ctrl

// File: doc/regfile_dump_ctrl.md
REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 SHALL have parameter B, default 32: register word width in bits.
REQ-002 SHALL have parameter W, default 5: register address width; register count is 2**W.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-004 SHALL have port clk, input, 1: system clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port dump_req, input, 1: one-cycle request to dump all registers.
REQ-007 SHALL have port pipe_idle, input, 1: pipeline drained, no register write in flight.
REQ-008 SHALL have port pipe_rd_addr, input, W: pipeline's read-port-1 address.
REQ-009 SHALL have port rf_rd_addr, output, W: address driven to register-file read port 1.
REQ-010 SHALL have port rf_rd_data, input, B: combinational read data from port 1.
REQ-011 SHALL have port stall, output, 1: freezes the pipeline and blocks register writes.
REQ-012 SHALL have port tx_data, output, 8: byte to UART transmitter.
REQ-013 SHALL have port tx_start, output, 1: one-cycle pulse launching tx_data.
REQ-014 SHALL have port tx_done, input, 1: one-cycle pulse when the UART finishes a byte.
REQ-015 SHALL have port busy, output, 1: dump in progress (any state other than IDLE).
REQ-016 SHALL have port dump_done, output, 1: one-cycle pulse after the last byte completes.

Function
REQ-017 SHALL use the states IDLE, DRAIN, ADDR, LATCH, SEND, WAIT, NEXT and DONE.
REQ-018 IDLE: on dump_req=1, SHALL go to DRAIN; stall SHALL assert from the next cycle.
REQ-019 DRAIN: SHALL hold until pipe_idle=1, then go to ADDR; reg_idx SHALL be 0 on entry.
REQ-020 ADDR: SHALL drive rf_rd_addr=reg_idx for one cycle, then go to LATCH.
REQ-021 LATCH: SHALL capture rf_rd_data into a B-bit shift register, set byte_cnt=0, then go to SEND.
REQ-022 SEND: SHALL pulse tx_start one cycle with tx_data = most significant byte of the shift register, then go to WAIT.
REQ-023 WAIT: on tx_done, SHALL shift the register left 8 bits; if byte_cnt=B/8-1, go to NEXT, else increment byte_cnt and go to SEND.
REQ-024 NEXT: if reg_idx=2**W-1, SHALL go to DONE; else increment reg_idx and go to ADDR.
REQ-025 DONE: SHALL pulse dump_done one cycle, deassert stall, and return to IDLE.
REQ-026 rf_rd_addr SHALL equal pipe_rd_addr in IDLE and DRAIN, and reg_idx in all other states.
REQ-027 Byte order SHALL be register 0 first, each word MSB first: 2**W*B/8 bytes in total (128 at defaults).
REQ-028 dump_req while busy=1 SHALL be ignored and not queued.
REQ-029 A tx_done outside WAIT SHALL be ignored.
REQ-030 reg_idx SHALL be W bits wide; wrap-around is never reached because NEXT exits at 2**W-1.
REQ-031 stall SHALL stay high continuously from DRAIN through DONE inclusive.

Reset
REQ-032 Reset SHALL force IDLE at any time, including mid-dump, with no partial-byte completion.
REQ-033 Reset SHALL clear stall, tx_start, busy and dump_done to 0, set tx_data to 0x00, and clear reg_idx, byte_cnt and the shift register to 0.

Structure
REQ-034 State encodings and the byte width constant 8 SHALL live in the shared package used by the debug unit.
REQ-035 The block SHALL be a single module; no sub-module is required.
REQ-036 The read-address mux SHALL be the only combinational output path; all other outputs SHALL be registered.

Verification
REQ-037 Bench SHALL preload reg k = 0xA0B0C000+k, pulse dump_req with pipe_idle=1, and a UART model returning tx_done 10 cycles after each tx_start -> 128 bytes A0,B0,C0,00,A0,B0,C0,01,...,A0,B0,C0,1F, then one dump_done pulse.
REQ-038 Bench SHALL hold pipe_idle=0 for 20 cycles after dump_req -> stall=1, no tx_start, rf_rd_addr tracks pipe_rd_addr until pipe_idle rises.
REQ-039 Bench SHALL pulse dump_req again during register 5 -> ignored; exactly 128 bytes and one dump_done.
REQ-040 Bench SHALL assert reset during register 17 byte 2 -> next cycle stall=0, busy=0, tx_start=0; a new dump_req restarts at register 0.
REQ-041 Bench SHALL inject spurious tx_done in IDLE and in SEND -> no state change, byte stream unchanged.
REQ-042 Bench SHALL, in IDLE, sweep pipe_rd_addr 0..31 -> rf_rd_addr equals it in the same cycle.
